// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-path types and constants
package core_pkg;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/core_fetch_slot.sv
// rtl/core_fetch_slot.sv - single-entry fetched-instruction buffer for decode
module core_fetch_slot #(
  parameter logic [31:0] EMPTY_INST = core_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        flush,
  input  logic        consume,
  output logic        valid,
  output logic [31:0] inst
);

  // flush beats load so redirect-time data never reaches decode
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      inst  <= EMPTY_INST;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= data;
    end else if (consume) begin
      valid <= 1'b0;
      inst  <= EMPTY_INST;
    end
  end

endmodule

// File: rtl/core_fetch_ctrl.sv
// rtl/core_fetch_ctrl.sv - fetch sequencer: imem handshake, PC advance/redirect, decode slot
module core_fetch_ctrl #(
  parameter int          BOOT_DELAY = 2,
  parameter logic [31:0] NOP_INST   = core_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] j_target,
  input  logic        id_stall,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_go,
  output logic [1:0]  pc_src,
  output logic [31:0] redir_addr,
  output logic        stall,
  output logic        if_valid,
  output logic [31:0] if_inst
);
  import core_pkg::*;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

  fetch_state_e state;
  logic [3:0]   boot_cnt;
  logic [1:0]   pend_src;
  logic [31:0]  pend_addr;

  logic         consume, slot_free, redir, load, flush_slot;
  logic [1:0]   live_src;
  logic [31:0]  live_addr;

  assign consume   = if_valid & ~id_stall;
  assign slot_free = ~if_valid | consume;
  assign redir     = br_taken | jump;
  assign live_src  = br_taken ? PC_SRC_BR : PC_SRC_J;
  assign live_addr = br_taken ? br_target : j_target;

  // pend_addr doubles as the held redirect address outside redirect cycles
  always_comb begin
    imem_req   = 1'b0;
    pc_go      = 1'b0;
    pc_src     = PC_SRC_SEQ;
    stall      = 1'b1;
    redir_addr = pend_addr;
    case (state)
      FETCH_REQ: begin
        imem_req = slot_free;
        stall    = if_valid & id_stall;
        if (redir) begin
          redir_addr = live_addr;
          if (!slot_free || imem_ack) begin
            pc_go  = 1'b1;
            pc_src = live_src;
          end
        end else if (slot_free && imem_ack) begin
          pc_go = 1'b1;
        end
      end
      FETCH_FLUSH: begin
        imem_req = 1'b1;
        if (redir) redir_addr = live_addr;
        if (imem_ack) begin
          pc_go  = 1'b1;
          pc_src = redir ? live_src : pend_src;
        end
      end
      default: ;
    endcase
  end

  assign load       = (state == FETCH_REQ) & slot_free & imem_ack & ~redir;
  assign flush_slot = (state == FETCH_REQ) & redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_IDLE;
      boot_cnt  <= 4'd0;
      pend_src  <= PC_SRC_SEQ;
      pend_addr <= 32'd0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (boot_cnt == BOOT_LAST) begin
            state    <= FETCH_REQ;
            boot_cnt <= 4'd0;
          end else begin
            boot_cnt <= boot_cnt + 4'd1;
          end
        end
        FETCH_REQ: begin
          if (redir) begin
            pend_src  <= live_src;
            pend_addr <= live_addr;
            // an issued request cannot be withdrawn; wait for its ack
            if (slot_free && !imem_ack) state <= FETCH_FLUSH;
          end
        end
        FETCH_FLUSH: begin
          if (redir) begin
            pend_src  <= live_src;
            pend_addr <= live_addr;
          end
          if (imem_ack) state <= FETCH_REQ;
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  core_fetch_slot #(.EMPTY_INST(NOP_INST)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (imem_rdata),
    .flush   (flush_slot),
    .consume (consume),
    .valid   (if_valid),
    .inst    (if_inst)
  );

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// tb/tb_core_fetch_ctrl.sv - self-checking bench for core_fetch_ctrl
module tb_core_fetch_ctrl;

  localparam int          BD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, br_taken, jump, id_stall, imem_ack;
  logic [31:0] br_target, j_target, imem_rdata;
  logic        imem_req, pc_go, stall, if_valid;
  logic [1:0]  pc_src;
  logic [31:0] redir_addr, if_inst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_fetch_ctrl #(.BOOT_DELAY(BD), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .j_target   (j_target),
    .id_stall   (id_stall),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_go      (pc_go),
    .pc_src     (pc_src),
    .redir_addr (redir_addr),
    .stall      (stall),
    .if_valid   (if_valid),
    .if_inst    (if_inst)
  );

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        ids;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic        e_go;
    logic [1:0]  e_src;
    logic        e_chk;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vec[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic ids, input logic ack, input logic [31:0] rd);
    rst = r; br_taken = b; br_target = bt; jump = j; j_target = jt;
    id_stall = ids; imem_ack = ack; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic req, input logic go, input logic [1:0] src,
                          input logic stl, input logic vld, input logic [31:0] inst);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, "_go"}, {31'd0, pc_go}, {31'd0, go});
    if (go) chk({tag, "_src"}, {30'd0, pc_src}, {30'd0, src});
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, stl});
    chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, vld});
    chk({tag, "_inst"}, if_inst, inst);
  endtask

  // reference model state for the random phase
  logic        m_booting, m_flush;
  int          m_boot;
  logic [1:0]  m_psrc;
  logic [31:0] m_paddr;
  logic [31:0] m_slot[$];

  logic        r_i, b_i, j_i, ids_i, ack_i;
  logic [31:0] bt_i, jt_i, rd_i;
  logic        full, take, room, rd_any, e_req, e_go, e_stall, e_chk;
  logic [1:0]  e_src, l_src;
  logic [31:0] e_addr, l_addr;

  initial begin
    //           rst   br    bt          jmp   jt     ids   ack   rd            req   go    src    chk   addr        stl   vld   inst
    vec[0]  = '{1'b1, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
    vec[1]  = '{1'b1, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
    vec[3]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
    vec[4]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b1, 32'h11,       1'b1, 1'b1, 2'd0,  1'b0, 32'h0,      1'b0, 1'b0, 32'h0};
    vec[5]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b1, 32'h22,       1'b1, 1'b1, 2'd0,  1'b0, 32'h0,      1'b0, 1'b1, 32'h11};
    vec[6]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b1, 32'h33,       1'b1, 1'b1, 2'd0,  1'b0, 32'h0,      1'b0, 1'b1, 32'h22};
    vec[7]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b1, 32'h33};
    vec[8]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 1'b1, 32'hBAD,      1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b1, 32'h33};
    vec[9]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b1, 32'h33};
    vec[10] = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b1, 32'h33};
    vec[11] = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b1, 32'h44,       1'b1, 1'b1, 2'd0,  1'b0, 32'h0,      1'b0, 1'b1, 32'h33};
    vec[12] = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0,  1'b0, 32'h0,      1'b1, 1'b1, 32'h44};
    vec[13] = '{1'b0, 1'b1, 32'h100,    1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd1,  1'b1, 32'h100,    1'b1, 1'b1, 32'h44};
    vec[14] = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'd0,  1'b0, 32'h0,      1'b0, 1'b0, 32'h0};

    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vec[i].rst, vec[i].br, vec[i].bt, vec[i].jmp, vec[i].jt, vec[i].ids, vec[i].ack, vec[i].rd);
      #3;
      expect_o($sformatf("tbl%0d", i), vec[i].e_req, vec[i].e_go, vec[i].e_src,
               vec[i].e_stall, vec[i].e_valid, vec[i].e_inst);
      if (vec[i].e_chk) chk($sformatf("tbl%0d_addr", i), redir_addr, vec[i].e_addr);
      tick();
    end

    // jump while a request is outstanding; ack arrives three cycles later
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    #3; expect_o("jA0", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, NOP); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3; expect_o("jA1", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, NOP); tick();
    #3; expect_o("jA2", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, NOP); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD);
    #3; expect_o("jA3", 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, NOP);
    chk("jA3_addr", redir_addr, 32'h200); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3; expect_o("jA4", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, NOP); tick();

    // branch+jump together, newer branch during flush, then reset mid-flush
    drive(1'b0, 1'b1, 32'h150, 1'b1, 32'h250, 1'b0, 1'b0, 32'h0);
    #3; expect_o("bB0", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, NOP);
    chk("bB0_addr", redir_addr, 32'h150); tick();
    drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3; expect_o("bB1", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, NOP); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBEEF);
    #3; expect_o("bB2", 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, NOP);
    chk("bB2_addr", redir_addr, 32'h300); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    #3; expect_o("bB3", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, NOP); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3; chk("bB4_req", {31'd0, imem_req}, 32'd1); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    #3; expect_o("bB5", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, NOP); tick();

    // randomized phase against the behavioural model
    for (int i = 0; i < 3000; i++) begin
      r_i   = (i < 2) || ($urandom_range(0, 199) == 0);
      b_i   = ($urandom_range(0, 9) == 0);
      j_i   = ($urandom_range(0, 9) == 0);
      ids_i = ($urandom_range(0, 2) == 0);
      ack_i = $urandom_range(0, 1);
      bt_i  = $urandom; jt_i = $urandom; rd_i = $urandom;
      drive(r_i, b_i, bt_i, j_i, jt_i, ids_i, ack_i, rd_i);
      #3;
      if (i >= 2) begin
        full   = (m_slot.size() != 0);
        take   = full && !ids_i;
        room   = !full || take;
        rd_any = b_i || j_i;
        l_src  = b_i ? 2'd1 : 2'd2;
        l_addr = b_i ? bt_i : jt_i;
        e_go = 1'b0; e_src = 2'd0; e_chk = 1'b0; e_addr = 32'h0;
        if (m_booting) begin
          e_req = 1'b0; e_stall = 1'b1;
        end else if (m_flush) begin
          e_req = 1'b1; e_stall = 1'b1;
          if (ack_i) begin
            e_go = 1'b1; e_chk = 1'b1;
            e_src  = rd_any ? l_src : m_psrc;
            e_addr = rd_any ? l_addr : m_paddr;
          end
        end else begin
          e_req = room; e_stall = full && ids_i;
          if (rd_any && (!room || ack_i)) begin
            e_go = 1'b1; e_src = l_src; e_chk = 1'b1; e_addr = l_addr;
          end else if (!rd_any && room && ack_i) begin
            e_go = 1'b1;
          end
        end
        expect_o($sformatf("rnd%0d", i), e_req, e_go, e_src, e_stall, full,
                 full ? m_slot[0] : NOP);
        if (e_chk) chk($sformatf("rnd%0d_addr", i), redir_addr, e_addr);
      end
      // advance the model across the clock edge
      if (r_i) begin
        m_booting = 1'b1; m_boot = 0; m_flush = 1'b0;
        m_psrc = 2'd0; m_paddr = 32'h0; m_slot.delete();
      end else if (m_booting) begin
        m_boot++;
        if (m_boot == BD) m_booting = 1'b0;
      end else if (m_flush) begin
        if (rd_any) begin m_psrc = l_src; m_paddr = l_addr; end
        if (ack_i) m_flush = 1'b0;
      end else if (rd_any) begin
        m_slot.delete();
        m_psrc = l_src; m_paddr = l_addr;
        if (room && !ack_i) m_flush = 1'b1;
      end else if (room && ack_i) begin
        m_slot.delete();
        m_slot.push_back(rd_i);
      end else if (take) begin
        m_slot.delete();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
